gcm_result_capture: RTL and testbench
=====================================

# gcm_result_capture

Capture-and-hold stage placed directly upstream of the seven-segment display driver. It handshakes the 128-bit result off the AES-GCM core and times the operation in clock cycles from launch to result. It then holds both values stable as the `i_x` / `in_count` inputs of the display. A timeout saturates the count at the display's blanking threshold, so a hung core shows all zeros.

## Interface
- `CNT_W`, 32: cycle-counter and `o_count` width.
- `TIMEOUT`, 32'h3b9aca00: saturation / timeout value; equal to the display's blanking threshold.
- `EXPECTED`, 128'h0: golden result used only when `GCM_CAPTURE_CHECK_EN` is defined.
- `clk`  in  1  system clock; single clock domain.
- `clr`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle launch pulse, issued alongside the GCM core's start.
- `in_valid`  in  1  GCM result valid.
- `in_data`  in  [0:127]  GCM result; bit 0 is MSB.
- `in_ready`  out  1  block accepts a result.
- `o_x`  out  [0:127]  held result, feeds the display's `i_x`.
- `o_count`  out  [0:CNT_W-1]  held cycle count, feeds the display's `in_count`.
- `busy`  out  1  measurement in progress.
- `done`  out  1  a result or timeout is held.
- `timeout`  out  1  last measurement timed out.
- `match`  out  1  held result equals `EXPECTED`.

## Operation
- FSM states:
  - IDLE (reset state).
  - RUN.
  - HOLD.
- State transitions:
  - IDLE --start--> RUN.
  - RUN --accept or timeout--> HOLD.
  - HOLD --start--> RUN.
  - `start` while in RUN is ignored.
- Internal counter `cnt`:
  - Cleared to 0 on the edge that enters RUN.
  - Increments by 1 every RUN cycle.
  - Never wraps.
- `in_ready` = (state == RUN), decoded from the state register only.
- Accept occurs when `in_valid && in_ready`. On the accepting edge:
  - `o_x` <= `in_data`.
  - `o_count` <= min(`cnt`+1, `TIMEOUT`).
  - `timeout` <= 0.
  - Go to HOLD.
- Timeout occurs when `cnt`+1 == `TIMEOUT` with no accept that cycle. On that edge:
  - `o_x` <= 0.
  - `o_count` <= `TIMEOUT`.
  - `timeout` <= 1.
  - Go to HOLD.
- If accept and timeout fall on the same cycle, accept wins: `o_count` = `TIMEOUT`, `timeout` = 0.
- `in_valid` in IDLE or HOLD is ignored; no data is taken.
- `o_x`, `o_count`, `timeout` and `match` persist through RUN until the next accept or timeout. The display keeps showing the previous result during a new measurement.
- `busy` = (state == RUN); `done` = (state == HOLD).

## Timing
- Reset values: state IDLE, `cnt` 0, `o_x` 0, `o_count` 0, `in_ready` 0, `busy` 0, `done` 0, `timeout` 0, `match` 0.
- `clr` is sampled on `clk`. Asserting `clr` in any state (including mid-RUN) restores all reset values on that edge. `clr` has priority over `start` and accept.
- `start` at edge N: `busy` = 1 and `in_ready` = 1 from N+1.
- If `in_valid` is first high in the first RUN cycle: `o_count` = 1 and `done` = 1 on the following edge.
- Latency from accept edge to `o_x` / `o_count` / `done` update: 0 cycles; all are registered on the accept edge.
- `match` updates one cycle after `o_x`.
- All outputs are registered or decoded from state; no combinational path from inputs to outputs.

## Configuration
- `GCM_CAPTURE_CHECK_EN` defined:
  - `match` is registered as (`o_x` == `EXPECTED`), updated on the cycle after each accept.
  - `match` is forced to 0 on timeout.
- `GCM_CAPTURE_CHECK_EN` undefined:
  - No comparator is built.
  - `match` is tied to 0.
  - `EXPECTED` is unused.

## Structure
- Package `gcm_disp_pkg` holds:
  - The state enum `cap_state_t` (IDLE, RUN, HOLD).
  - The constant `DISP_BLANK_COUNT` = 32'h3b9aca00; this is the default for `TIMEOUT` and is shared with the display driver.
  - The 128-bit block type `gcm_block_t`.
- Sub-module `sat_cycle_counter`:
  - Inputs: clear, enable.
  - Outputs: count, `hit` when the next count reaches `TIMEOUT`.
  - Instantiated once.

## Test plan
- Basic accept: `clr` pulse, `start`, `in_valid` with `in_data` = 128'h0123…cdef on the 5th RUN cycle -> `o_x` = that value, `o_count` = 5, `done` = 1, `timeout` = 0.
- Timeout: `TIMEOUT` = 16, `start`, no `in_valid` -> after 16 RUN cycles `o_count` = 16, `o_x` = 0, `timeout` = 1, `done` = 1.
- Simultaneous accept and timeout: `TIMEOUT` = 8, `in_valid` on RUN cycle 8 -> data captured, `o_count` = 8, `timeout` = 0.
- Ignored inputs: `in_valid` in IDLE and in HOLD, and `start` mid-RUN -> outputs unchanged, `cnt` not restarted.
- Reset mid-RUN: `clr` on RUN cycle 3 -> next cycle every output equals its reset value; a later `start` measures from 1 again.
- Check feature: with `GCM_CAPTURE_CHECK_EN`, accept `in_data` == `EXPECTED` -> `match` = 1 one cycle after `done`. Accept any other value -> `match` = 0. Without the macro, `match` = 0 always.

Source files
------------

// File: rtl/gcm_disp_pkg.sv
// Shared types and constants for the GCM result capture stage and the
// seven-segment display driver it feeds.
package gcm_disp_pkg;

    localparam logic [31:0] DISP_BLANK_COUNT = 32'h3b9aca00;

    typedef logic [0:127] gcm_block_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } cap_state_t;

endpackage

// File: rtl/sat_cycle_counter.sv
// Cycle counter that stops at LIMIT; hit flags the cycle whose
// increment would reach LIMIT.
module sat_cycle_counter #(
    parameter int               CNT_W = 32,
    parameter logic [CNT_W-1:0] LIMIT = '1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             hit
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (en && count != LIMIT) begin
            count <= count + ONE;
        end
    end

    assign hit = en && ((count + ONE) == LIMIT);

endmodule

// File: rtl/gcm_result_capture.sv
// Captures and holds the AES-GCM result and its cycle count for the display.
// Optional golden-result compare: define GCM_CAPTURE_CHECK_EN.
module gcm_result_capture
    import gcm_disp_pkg::*;
#(
    parameter int               CNT_W    = 32,
    parameter logic [CNT_W-1:0] TIMEOUT  = CNT_W'(DISP_BLANK_COUNT),
    parameter gcm_block_t       EXPECTED = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             in_valid,
    input  logic [0:127]     in_data,
    output logic             in_ready,
    output logic [0:127]     o_x,
    output logic [0:CNT_W-1] o_count,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             match
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    cap_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] nxt;
    logic             hit;
    logic             acc;
    logic             expire;
    logic             launch;

    assign in_ready = (state == RUN);
    assign busy     = (state == RUN);
    assign done     = (state == HOLD);

    assign acc    = in_valid && (state == RUN);
    assign expire = hit && !acc;
    assign launch = start && (state != RUN);
    assign nxt    = cnt + ONE;

    sat_cycle_counter #(
        .CNT_W (CNT_W),
        .LIMIT (TIMEOUT)
    ) u_cnt (
        .clk   (clk),
        .clear (clr || launch),
        .en    (state == RUN),
        .count (cnt),
        .hit   (hit)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= IDLE;
            o_x     <= '0;
            o_count <= '0;
            timeout <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) state <= RUN;
                end
                RUN: begin
                    if (in_valid) begin
                        o_x     <= in_data;
                        o_count <= (nxt > TIMEOUT) ? TIMEOUT : nxt;
                        timeout <= 1'b0;
                        state   <= HOLD;
                    end else if (hit) begin
                        o_x     <= '0;
                        o_count <= TIMEOUT;
                        timeout <= 1'b1;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (start) state <= RUN;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GCM_CAPTURE_CHECK_EN
    logic chk;

    // Compare against the registered o_x, one cycle after the accept.
    always_ff @(posedge clk) begin
        if (clr) begin
            chk   <= 1'b0;
            match <= 1'b0;
        end else begin
            chk <= acc;
            if (expire) begin
                match <= 1'b0;
            end else if (chk) begin
                match <= (o_x == EXPECTED);
            end
        end
    end
`else
    assign match = 1'b0;
`endif

endmodule

// File: tb/tb_gcm_result_capture.sv
// Randomised and directed bench for gcm_result_capture against a
// measurement-level reference model.
module tb_gcm_result_capture;

    localparam int          T   = 16;
    localparam logic [127:0] EXP =
        128'h0123456789abcdef0123456789abcdef;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [0:127]  in_data = '0;
    logic          in_ready;
    logic [0:127]  o_x;
    logic [0:31]   o_count;
    logic          busy;
    logic          done;
    logic          timeout;
    logic          match;

    int n_cmp = 0;
    int n_bad = 0;

    bit check_en;

    // reference model: measurement state in plain terms
    bit           m_running;
    bit           m_holding;
    int           m_elapsed;
    logic [127:0] m_x;
    int           m_count;
    bit           m_to;
    bit           m_match;
    bit           m_pend;

    gcm_result_capture #(
        .CNT_W    (32),
        .TIMEOUT  (32'(T)),
        .EXPECTED (EXP)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .o_x      (o_x),
        .o_count  (o_count),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout),
        .match    (match)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [127:0] got,
                         input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_running = 0;
        m_holding = 0;
        m_elapsed = 0;
        m_x       = '0;
        m_count   = 0;
        m_to      = 0;
        m_match   = 0;
        m_pend    = 0;
    endtask

    task automatic model_edge();
        logic [127:0] old_x;
        bit           was_pend;
        if (clr) begin
            model_reset();
            return;
        end
        old_x    = m_x;
        was_pend = m_pend;
        m_pend   = 0;
        if (was_pend && check_en) m_match = (old_x == EXP);
        if (m_running) begin
            m_elapsed++;
            if (in_valid) begin
                m_x       = in_data;
                m_count   = (m_elapsed > T) ? T : m_elapsed;
                m_to      = 0;
                m_running = 0;
                m_holding = 1;
                m_pend    = 1;
            end else if (m_elapsed == T) begin
                m_x       = '0;
                m_count   = T;
                m_to      = 1;
                m_match   = 0;
                m_running = 0;
                m_holding = 1;
            end
        end else if (start) begin
            m_running = 1;
            m_holding = 0;
            m_elapsed = 0;
        end
    endtask

    task automatic compare_all();
        check("busy", 128'(busy), 128'(m_running));
        check("in_ready", 128'(in_ready), 128'(m_running));
        check("done", 128'(done), 128'(m_holding));
        check("o_x", o_x, m_x);
        check("o_count", 128'(o_count), 128'(m_count));
        check("timeout", 128'(timeout), 128'(m_to));
        check("match", 128'(match), 128'(m_match));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_in();
        clr = 0; start = 0; in_valid = 0;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
`ifdef GCM_CAPTURE_CHECK_EN
        check_en = 1;
`else
        check_en = 0;
`endif
        model_reset();
        #2;

        // reset
        clr = 1; tick(); idle_in();
        check("rst_count", 128'(o_count), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);

        // in_valid in IDLE is ignored
        in_valid = 1; in_data = ~EXP; tick(); idle_in();
        check("idle_valid_x", o_x, 128'd0);
        check("idle_valid_busy", 128'(busy), 128'd0);

        // basic accept on 5th RUN cycle
        start = 1; tick(); idle_in();
        check("start_ready", 128'(in_ready), 128'd1);
        run_cycles(3);
        tick();
        in_valid = 1; in_data = EXP; tick(); idle_in();
        check("basic_x", o_x, EXP);
        check("basic_count", 128'(o_count), 128'd5);
        check("basic_done", 128'(done), 128'd1);
        check("basic_to", 128'(timeout), 128'd0);
        tick();
        check("basic_match", 128'(match), 128'(check_en));

        // in_valid in HOLD is ignored
        in_valid = 1; in_data = ~EXP; tick(); idle_in();
        check("hold_valid_x", o_x, EXP);

        // timeout after T RUN cycles
        start = 1; tick(); idle_in();
        run_cycles(T - 1);
        check("prev_held_x", o_x, EXP);
        tick();
        check("to_count", 128'(o_count), 128'(T));
        check("to_x", o_x, 128'd0);
        check("to_flag", 128'(timeout), 128'd1);
        check("to_done", 128'(done), 128'd1);
        check("to_match", 128'(match), 128'd0);

        // start mid-RUN does not restart the count
        start = 1; tick(); idle_in();
        run_cycles(3);
        start = 1; tick(); idle_in();
        run_cycles(3);
        in_valid = 1; in_data = 128'hdead_beef; tick(); idle_in();
        check("midstart_count", 128'(o_count), 128'd8);

        // accept and timeout on the same cycle
        start = 1; tick(); idle_in();
        run_cycles(T - 1);
        in_valid = 1; in_data = 128'h5a5a; tick(); idle_in();
        check("tie_x", o_x, 128'h5a5a);
        check("tie_count", 128'(o_count), 128'(T));
        check("tie_to", 128'(timeout), 128'd0);

        // clr on 3rd RUN cycle
        start = 1; tick(); idle_in();
        run_cycles(2);
        clr = 1; tick(); idle_in();
        check("clr_x", o_x, 128'd0);
        check("clr_count", 128'(o_count), 128'd0);
        check("clr_busy", 128'(busy), 128'd0);
        start = 1; tick(); idle_in();
        in_valid = 1; in_data = EXP; tick(); idle_in();
        check("restart_count", 128'(o_count), 128'd1);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            clr      = ($urandom_range(0, 99) == 0);
            start    = ($urandom_range(0, 5) == 0);
            in_valid = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 2) == 0) in_data = EXP;
            else in_data = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        idle_in();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
